// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states and flag layout.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int FLAG_GA = 2;
    localparam int FLAG_GB = 1;
    localparam int FLAG_E  = 0;

    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_settle_counter.sv
// Settle-window counter: cleared when an op is issued, counts while the ALU inputs settle.
module alu_settle_counter
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives a purely combinational ALU from registers, waits a settle window, then returns
// the sampled result and comparator flags over a valid/ready response channel.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [1:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_ga,
    input  logic             alu_gb,
    input  logic             alu_e,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [WIDTH-1:0] rsp_y,
    output logic [2:0]       rsp_flags,
    output logic             busy,
    output logic [7:0]       op_count
);

    state_t state, state_nx;

    logic       accept;
    logic       capture;
    logic       rsp_fire;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_done;
    logic [2:0] flags_in;

    // The compare op yields no ALU result, so its flags are reported as the result word.
    function automatic logic [WIDTH-1:0] map_result(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [2:0]       flags);
        return (op == OP_CMP) ? WIDTH'(flags) : y;
    endfunction

    assign accept   = req_valid & (state == IDLE);
    assign capture  = cnt_done  & (state == SETTLE);
    assign rsp_fire = rsp_ready & (state == RESP);

    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_GA] = alu_ga;
        flags_in[FLAG_GB] = alu_gb;
        flags_in[FLAG_E]  = alu_e;
    end

    alu_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .done(cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = SETTLE;
            SETTLE:  if (capture)  state_nx = RESP;
            RESP:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        cnt_clr   = accept;
        cnt_en    = (state == SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_s     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_op    <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                alu_s  <= req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
                rsp_op <= req_op;
            end
            if (capture) begin
                rsp_y     <= map_result(alu_s, alu_y, flags_in);
                rsp_flags <= flags_in;
            end
            if (rsp_fire) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the 4-bit ALU attached.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_a = 4'h0;
    logic [3:0] req_b = 4'h0;
    logic [1:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_ga;
    logic       alu_gb;
    logic       alu_e;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_op;
    logic [3:0] rsp_y;
    logic [2:0] rsp_flags;
    logic       busy;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .WIDTH        (4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .alu_s    (alu_s),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_ga   (alu_ga),
        .alu_gb   (alu_gb),
        .alu_e    (alu_e),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op   (rsp_op),
        .rsp_y    (rsp_y),
        .rsp_flags(rsp_flags),
        .busy     (busy),
        .op_count (op_count)
    );

    // Combinational ALU: compare produces no result word, comparator is always live.
    always_comb begin
        case (alu_s)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b11:   alu_y = alu_a & alu_b;
            default: alu_y = 4'h0;
        endcase
        alu_ga = (alu_a > alu_b);
        alu_gb = (alu_b > alu_a);
        alu_e  = (alu_a == alu_b);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents a request, waits for acceptance, returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Returns at a negedge where rsp_valid is high.
    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout rsp_valid=%0b required 1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 100", {req_ready, rsp_valid, busy});
        end
        checks++;
        if ({alu_s, alu_a, alu_b, rsp_op, rsp_y, rsp_flags, op_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_data got %h required 0",
                     {alu_s, alu_a, alu_b, rsp_op, rsp_y, rsp_flags, op_count});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 4'd3;
        req_b     = 4'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, busy, alu_a, alu_b} !== {3'b001, 4'd3, 4'd5}) begin
            errors++;
            $display("FAIL add_accept got %b required 001_0011_0101",
                     {req_ready, rsp_valid, busy, alu_a, alu_b});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early_valid got %b required 0", rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_y, rsp_op, rsp_flags} !== {1'b1, 4'd8, 2'b00, 3'b010}) begin
            errors++;
            $display("FAIL add_rsp got %b required 1_1000_00_010",
                     {rsp_valid, rsp_y, rsp_op, rsp_flags});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({op_count, rsp_valid, req_ready} !== {8'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_done got count=%0d valid=%b ready=%b required 1 0 1",
                     op_count, rsp_valid, req_ready);
        end
    endtask

    task automatic test_wrap_sub();
        do_reset();
        rsp_ready = 1'b1;
        issue(2'b00, 4'd9, 4'd9);
        wait_rsp();
        checks++;
        if (rsp_y !== 4'd2) begin
            errors++;
            $display("FAIL add_wrap got %0d required 2", rsp_y);
        end
        @(posedge clk);
        @(negedge clk);
        issue(2'b01, 4'd7, 4'd2);
        wait_rsp();
        checks++;
        if ({rsp_y, rsp_op} !== {4'd5, 2'b01}) begin
            errors++;
            $display("FAIL sub got y=%0d op=%b required 5 01", rsp_y, rsp_op);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_count !== 8'd2) begin
            errors++;
            $display("FAIL sub_count got %0d required 2", op_count);
        end
    endtask

    task automatic test_compare();
        issue(2'b10, 4'd6, 4'd3);
        wait_rsp();
        checks++;
        if ({rsp_flags, rsp_y, rsp_op} !== {3'b100, 4'b0100, 2'b10}) begin
            errors++;
            $display("FAIL cmp_gt got flags=%b y=%b op=%b required 100 0100 10",
                     rsp_flags, rsp_y, rsp_op);
        end
        @(posedge clk);
        @(negedge clk);
        issue(2'b10, 4'd5, 4'd5);
        wait_rsp();
        checks++;
        if ({rsp_flags, rsp_y} !== {3'b001, 4'b0001}) begin
            errors++;
            $display("FAIL cmp_eq got flags=%b y=%b required 001 0001", rsp_flags, rsp_y);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        rsp_ready = 1'b0;
        issue(2'b11, 4'hC, 4'hA);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 4'd1;
        req_b     = 4'd2;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_y, rsp_op, req_ready, alu_s, alu_a} !==
                {1'b1, 4'h8, 2'b11, 1'b0, 2'b11, 4'hC}) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL and_hold got %0d unstable cycles required 0", bad);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, alu_s, op_count} !== {1'b0, 1'b1, 2'b11, 8'd5}) begin
            errors++;
            $display("FAIL and_release got valid=%b ready=%b s=%b count=%0d required 0 1 11 5",
                     rsp_valid, req_ready, alu_s, op_count);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({busy, alu_s, alu_a, alu_b} !== {1'b1, 2'b00, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL second_accept got busy=%b s=%b a=%0d b=%0d required 1 00 1 2",
                     busy, alu_s, alu_a, alu_b);
        end
        wait_rsp();
        checks++;
        if (rsp_y !== 4'd3) begin
            errors++;
            $display("FAIL second_rsp got %0d required 3", rsp_y);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        rsp_ready = 1'b1;
        issue(2'b00, 4'd1, 4'd1);
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, busy, req_ready, alu_s, alu_a, alu_b, rsp_op, rsp_y, rsp_flags, op_count}
            !== {3'b001, 27'd0}) begin
            errors++;
            $display("FAIL rst_mid got %h required 1",
                     {rsp_valid, busy, req_ready, alu_s, alu_a, alu_b, rsp_op, rsp_y,
                      rsp_flags, op_count});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_dropped got bad=%0d count=%0d required 0 0", bad, op_count);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int first = -1;
        int last = -1;
        int bad_y = 0;
        rsp_ready = 1'b1;
        req_op    = 2'b00;
        req_a     = 4'd1;
        req_b     = 4'd1;
        req_valid = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n++;
                if (first < 0) first = c;
                last = c;
                if (rsp_y !== 4'd2) bad_y++;
                if (n == 256) break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (n != 256 || bad_y != 0) begin
            errors++;
            $display("FAIL b2b_count got n=%0d bad_y=%0d required 256 0", n, bad_y);
        end
        checks++;
        if (last - first != 1020) begin
            errors++;
            $display("FAIL b2b_rate got span=%0d required 1020", last - first);
        end
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL b2b_pre_wrap got %0d required 255", op_count);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({op_count, rsp_valid} !== {8'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_wrap got count=%0d valid=%b required 0 0", op_count, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_wrap_sub();
        test_compare();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Initiator-side controller for the 4-bit gate-level ALU. It accepts operation requests over a valid/ready handshake and drives the ALU select and operand lines from registers. It holds those lines stable for a programmable settle window, then samples the ALU result and the comparator flags. It returns the sampled result over a second valid/ready handshake, so the purely combinational ALU can sit in a clocked datapath.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width; must match the ALU.
- `SETTLE_CYCLES`, 2: cycles the ALU inputs are held before sampling; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 2: operation code; 00 add, 01 sub, 10 compare, 11 and.
- `req_a` in WIDTH: operand a.
- `req_b` in WIDTH: operand b.
- `alu_s` out 2: ALU select, registered.
- `alu_a` out WIDTH: ALU operand a, registered.
- `alu_b` out WIDTH: ALU operand b, registered.
- `alu_y` in WIDTH: ALU result.
- `alu_ga`, `alu_gb`, `alu_e` in 1 each: comparator a>b, b>a, equal.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes response.
- `rsp_op` out 2: opcode of this response.
- `rsp_y` out WIDTH: result.
- `rsp_flags` out 3: {ga, gb, e} sampled with the result.
- `busy` out 1: high whenever state is not IDLE.
- `op_count` out 8: number of completed responses; wraps 255 -> 0.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`: load `alu_s`/`alu_a`/`alu_b` from `req_op`/`req_a`/`req_b`, latch `rsp_op`, clear the settle counter, go to SETTLE.
- SETTLE:
  - `req_ready` = 0; `alu_*` registers are frozen.
  - The counter increments each edge.
  - On the edge where counter == SETTLE_CYCLES-1: capture `alu_y` and `{alu_ga,alu_gb,alu_e}` into `rsp_y`/`rsp_flags`, go to RESP.
- Result mapping:
  - Ops 00, 01, 11: `rsp_y` = `alu_y`.
  - Op 10: the ALU drives no result, so `rsp_y` = {zeros, ga, gb, e}.
  - `rsp_flags` is always the sampled comparator outputs.
- RESP:
  - `rsp_valid` = 1; `rsp_y`, `rsp_flags`, `rsp_op` held stable while `rsp_ready` = 0.
  - On `rsp_valid & rsp_ready`: `op_count` += 1, return to IDLE.
- `alu_*` keep the last issued values outside SETTLE; they are not cleared on return to IDLE.
- Add/sub results are modulo 2^WIDTH. Carry and sign are not ALU ports and are not reported.

## Timing
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `busy` 0, `alu_s`/`alu_a`/`alu_b` 0, `rsp_y`/`rsp_flags`/`rsp_op` 0, `op_count` 0, counter 0.
- Latency: request accepted at edge E0 -> `rsp_valid` high after edge E0+SETTLE_CYCLES.
- Throughput: at best one operation per SETTLE_CYCLES+2 cycles. No accept in RESP, no bypass.
- `req_valid` in SETTLE/RESP: ignored. The requester must hold it until it sees `req_ready`.
- `rsp_ready` asserted outside RESP: no effect.
- Reset asserted mid-SETTLE or mid-RESP: immediate return to reset values; the in-flight op is dropped with no response and no `op_count` increment.
- `req_ready`, `rsp_valid` and `busy` are decoded from registered state only, with no combinational path from inputs.

## Structure
- Shared package `alu_seq_pkg`:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_AND=2'b11.
  - FSM state type {IDLE, SETTLE, RESP}.
  - Flag bit indices FLAG_GA=2, FLAG_GB=1, FLAG_E=0.
- One sub-module `alu_settle_counter`:
  - 4-bit counter with clear and enable.
  - `done` output when count == SETTLE_CYCLES-1.
- The top level holds the FSM, the ALU drive registers, the response registers and `op_count`.
- The bench connects the top level to the ALU itself.

## Test plan
- Add 3+5, SETTLE_CYCLES=2, `rsp_ready` held 1 -> `rsp_y`=8, `rsp_op`=00, `rsp_valid` rises 2 cycles after accept, `op_count`=1.
- Add 9+9 -> `rsp_y`=2 (wrap); then sub 7-2 -> `rsp_y`=5; `op_count`=2.
- Compare a=6, b=3 -> `rsp_flags`=3'b100, `rsp_y`=4'b0100. Compare a=5, b=5 -> `rsp_flags`=3'b001.
- AND 0xC & 0xA with `rsp_ready` held low 5 cycles:
  - Response stable at 0x8 throughout; `req_ready`=0 throughout.
  - Second request held on `req_valid` is accepted only after the response handshake plus one cycle.
- Assert `rst` one cycle after accepting add 1+1 -> no `rsp_valid`, all outputs 0, `req_ready`=1 after reset release, `op_count`=0.
- 256 back-to-back ops -> `op_count` wraps to 0.
